// File: rtl/mem_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank_writer
// Description : Queued host writes into a banked memory port. An optional
//               clear sweep is enabled by defining MEM_BANK_WRITER_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_writer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH       = 32,
    parameter int                    NUM_BANKS   = 2,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PTR_W  = $clog2(FIFO_DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BANK_W-1:0]     in_bank,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  write_allow,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  wea,
    output logic [BANK_W-1:0]     banka,
    output logic [ADDR_W-1:0]     addra,
    output logic [DATA_WIDTH-1:0] dia,
    output logic [LVL_W-1:0]      fifo_level
);

    localparam int               ENT_W    = BANK_W + ADDR_W + DATA_WIDTH;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ready_en_q;
    logic                  wea_q, wea_d;
    logic [BANK_W-1:0]     banka_q, banka_d;
    logic [ADDR_W-1:0]     addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dia_q, dia_d;
    logic                  accept_en, pop_en, sweep_wr;
    logic [BANK_W-1:0]     sweep_bank;
    logic [ADDR_W-1:0]     sweep_addr;
    logic                  push, pop;
    logic [ENT_W-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]      head;

    assign head       = fifo_mem_q[rd_ptr_q];
    // ready_en_q keeps in_ready low until the first edge after reset release
    assign in_ready   = ready_en_q && accept_en && (level_q != FULL_LVL);
    assign push       = in_valid && in_ready;
    assign pop        = pop_en && (level_q != '0) && write_allow;
    assign fifo_level = level_q;
    assign wea        = wea_q;
    assign banka      = banka_q;
    assign addra      = addra_q;
    assign dia        = dia_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        wea_d   = 1'b0;
        banka_d = banka_q;
        addra_d = addra_q;
        dia_d   = dia_q;
        if (pop) begin
            wea_d                       = 1'b1;
            {banka_d, addra_d, dia_d}   = head;
        end else if (sweep_wr) begin
            wea_d   = 1'b1;
            banka_d = sweep_bank;
            addra_d = sweep_addr;
            dia_d   = CLEAR_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {in_bank, in_addr, in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_en_q <= 1'b0;
            wea_q      <= 1'b0;
            banka_q    <= '0;
            addra_q    <= '0;
            dia_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_en_q <= 1'b1;
            wea_q      <= wea_d;
            banka_q    <= banka_d;
            addra_q    <= addra_d;
            dia_q      <= dia_d;
        end
    end

`ifdef MEM_BANK_WRITER_CLEAR_EN
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [BANK_W-1:0] sw_bank_q, sw_bank_d;
    logic [ADDR_W-1:0] sw_addr_q, sw_addr_d;
    logic              sweep_last;

    assign accept_en  = (state_q == ST_IDLE);
    assign pop_en     = (state_q != ST_CLEAR);
    assign sweep_wr   = (state_q == ST_CLEAR) && write_allow;
    assign sweep_bank = sw_bank_q;
    assign sweep_addr = sw_addr_q;
    assign sweep_last = (sw_bank_q == LAST_BANK) && (sw_addr_q == LAST_ADDR);
    assign clear_busy = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        sw_bank_d = sw_bank_q;
        sw_addr_d = sw_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) state_d = (level_q != '0) ? ST_DRAIN : ST_CLEAR;
            end
            ST_DRAIN: begin
                if (level_d == '0) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (write_allow) begin
                    if (sweep_last) begin
                        state_d   = ST_IDLE;
                        sw_bank_d = '0;
                        sw_addr_d = '0;
                    end else if (sw_addr_q == LAST_ADDR) begin
                        sw_addr_d = '0;
                        sw_bank_d = sw_bank_q + BANK_W'(1);
                    end else begin
                        sw_addr_d = sw_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sw_bank_q <= '0;
            sw_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            sw_bank_q <= sw_bank_d;
            sw_addr_q <= sw_addr_d;
        end
    end
`else
    logic unused_clear_req;

    assign unused_clear_req = clear_req;
    assign accept_en        = 1'b1;
    assign pop_en           = 1'b1;
    assign sweep_wr         = 1'b0;
    assign sweep_bank       = '0;
    assign sweep_addr       = '0;
    assign clear_busy       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bank_writer
// Description : Scoreboard bench for mem_bank_writer; clear scenarios run when
//               MEM_BANK_WRITER_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank_writer;

    localparam int DW = 8;
    localparam int BW = 1;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int EW = BW + AW + DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_bank;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          write_allow;
    logic          clear_req;
    logic          clear_busy;
    logic          wea;
    logic [BW-1:0] banka;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;
    logic [LW-1:0] fifo_level;

    int n_checks  = 0;
    int n_pass    = 0;
    int wea_count = 0;
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_bank_writer #(
        .DATA_WIDTH (8),
        .DEPTH      (32),
        .NUM_BANKS  (2),
        .FIFO_DEPTH (4),
        .CLEAR_VALUE(8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bank    (in_bank),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .write_allow(write_allow),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .wea        (wea),
        .banka      (banka),
        .addra      (addra),
        .dia        (dia),
        .fifo_level (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Monitor: every write pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (reset_n === 1'b1 && wea === 1'b1) begin
            wea_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_wea: got %0h expected no write", {banka, addra, dia});
            end else begin
                check("wea_entry", 32'({banka, addra, dia}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int b, input int a, input int d);
        in_valid = 1'b1;
        in_bank  = BW'(b);
        in_addr  = AW'(a);
        in_data  = DW'(d);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [EW-1:0] ent(input int b, input int a, input int d);
        return {BW'(b), AW'(a), DW'(d)};
    endfunction

    int fb[5] = '{0, 1, 0, 1, 0};
    int fa[5] = '{1, 2, 3, 4, 5};
    int fd[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int bp_allow[6] = '{1, 0, 1, 0, 1, 0};

    initial begin
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        in_bank     = '0;
        in_addr     = '0;
        in_data     = '0;
        write_allow = 1'b0;
        clear_req   = 1'b0;
        #1 reset_n  = 1'b0;
        #1;
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd0);
        check("rst_addra", 32'({banka, addra, dia}), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        tick();
        check("in_ready_after_release", 32'(in_ready), 32'd1);

        // Single write with minimum latency
        write_allow = 1'b1;
        exp_q.push_back(ent(1, 5, 8'hA3));
        push_one(1, 5, 8'hA3);
        check("single_level_after_push", 32'(fifo_level), 32'd1);
        tick();
        check("single_wea_k1", 32'(wea), 32'd1);
        check("single_level_after_pop", 32'(fifo_level), 32'd0);
        tick();
        check("single_wea_k2", 32'(wea), 32'd0);

        // Full queue: 4 accepted, 5th held off
        write_allow = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(ent(fb[i], fa[i], fd[i]));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bank  = BW'(fb[i]);
            in_addr  = AW'(fa[i]);
            in_data  = DW'(fd[i]);
            tick();
        end
        check("full_level", 32'(fifo_level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid    = 1'b0;
        write_allow = 1'b1;
        tick();
        check("full_ready_after_pop", 32'(in_ready), 32'd1);
        check("full_level_after_pop", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 5; i++) tick();
        check("full_drained", 32'(fifo_level), 32'd0);

        // Backpressure: pulses only after allowed edges
        write_allow = 1'b0;
        exp_q.push_back(ent(0, 7, 8'h5A));
        exp_q.push_back(ent(1, 31, 8'hFF));
        exp_q.push_back(ent(0, 0, 8'h01));
        push_one(0, 7, 8'h5A);
        push_one(1, 31, 8'hFF);
        push_one(0, 0, 8'h01);
        for (int i = 0; i < 6; i++) begin
            write_allow = bp_allow[i][0];
            tick();
            check("bp_wea", 32'(wea), 32'(bp_allow[i]));
        end
        check("bp_level", 32'(fifo_level), 32'd0);

        // Simultaneous push and pop keeps the level
        write_allow = 1'b0;
        exp_q.push_back(ent(1, 9, 8'h77));
        exp_q.push_back(ent(0, 10, 8'h88));
        push_one(1, 9, 8'h77);
        write_allow = 1'b1;
        push_one(0, 10, 8'h88);
        check("pushpop_level", 32'(fifo_level), 32'd1);
        tick();
        tick();
        check("pushpop_drained", 32'(fifo_level), 32'd0);

`ifdef MEM_BANK_WRITER_CLEAR_EN
        // Drain two queued writes, then sweep both banks
        write_allow = 1'b0;
        exp_q.push_back(ent(1, 3, 8'hC1));
        exp_q.push_back(ent(0, 4, 8'hC2));
        push_one(1, 3, 8'hC1);
        push_one(0, 4, 8'hC2);
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 32; a++) exp_q.push_back(ent(b, a, 0));
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clear_busy_rise", 32'(clear_busy), 32'd1);
        in_valid    = 1'b1;
        in_bank     = 1'b1;
        in_addr     = 5'd17;
        in_data     = 8'hEE;
        write_allow = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("clear_in_ready", 32'(in_ready), 32'd0);
        in_valid    = 1'b0;
        write_allow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clear_stall_wea", 32'(wea), 32'd0);
        end
        write_allow = 1'b1;
        for (int i = 0; i < 300 && clear_busy; i++) tick();
        check("clear_busy_fall", 32'(clear_busy), 32'd0);
        check("clear_all_written", 32'(exp_q.size()), 32'd0);
        check("clear_ready_back", 32'(in_ready), 32'd1);

        // Reset in the middle of a sweep
        begin
            int start;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 32; a++) exp_q.push_back(ent(b, a, 0));
            start     = wea_count;
            clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
            for (int i = 0; i < 100 && (wea_count - start) < 10; i++) begin
                @(negedge clk);
                #1;
            end
            check("sweep_reached_10", 32'(wea_count - start), 32'd10);
            reset_n = 1'b0;
            #1;
            check("mid_rst_wea", 32'(wea), 32'd0);
            check("mid_rst_busy", 32'(clear_busy), 32'd0);
            check("mid_rst_level", 32'(fifo_level), 32'd0);
            exp_q.delete();
            tick();
            reset_n = 1'b1;
            for (int i = 0; i < 80; i++) tick();
            check("no_sweep_after_rst", 32'(wea_count - start), 32'd10);
            check("post_rst_busy", 32'(clear_busy), 32'd0);
        end
`else
        // Clear request has no effect without the clear feature
        write_allow = 1'b1;
        clear_req   = 1'b1;
        tick();
        clear_req   = 1'b0;
        check("noclr_busy", 32'(clear_busy), 32'd0);
        check("noclr_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("noclr_busy_later", 32'(clear_busy), 32'd0);
        check("noclr_in_ready_later", 32'(in_ready), 32'd1);
        check("noclr_wea", 32'(wea), 32'd0);
`endif

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bank_writer.md
MEM_BANK_WRITER -- requirements
Module: mem_bank_writer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 8, write data width
- DEPTH, 32, words per bank
- NUM_BANKS, 2, bank count
- FIFO_DEPTH, 4, host write queue entries, power of 2, at least 2
- CLEAR_VALUE, 0, word written by the clear sweep
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock
- reset_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, host write request
- in_ready, out, 1, queue can accept a write
- in_bank, in, clog2(NUM_BANKS), target bank
- in_addr, in, clog2(DEPTH), target word
- in_data, in, DATA_WIDTH, write data
- write_allow, in, 1, memory write slot available this cycle
- clear_req, in, 1, one-cycle pulse requesting a full clear
- clear_busy, out, 1, clear pending or in progress
- wea, out, 1, memory write enable
- banka, out, clog2(NUM_BANKS), memory write bank
- addra, out, clog2(DEPTH), memory write address
- dia, out, DATA_WIDTH, memory write data
- fifo_level, out, clog2(FIFO_DEPTH)+1, current queue occupancy
REQ-003 Clock and reset SHALL be exactly one clock, clk, and an asynchronous active-low reset, reset_n.

Function
REQ-004 A write SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-005 in_ready SHALL be 1 only when the state is IDLE and fifo_level < FIFO_DEPTH; no push SHALL occur when the queue is full, even if a pop happens in the same cycle.
REQ-006 The FIFO SHALL preserve order and SHALL pop the head on an edge where the state is IDLE, the FIFO is non-empty and write_allow=1.
REQ-007 wea, banka, addra and dia SHALL be registered: after each pop edge they SHALL hold the popped entry with wea=1 for exactly one cycle, and wea SHALL be 0 otherwise.
REQ-008 Minimum latency SHALL be: an entry accepted at edge k, with write_allow held at 1, appears with wea=1 after edge k+1.
REQ-009 A push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-010 fifo_level SHALL never exceed FIFO_DEPTH or wrap below 0.
REQ-011 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 The state machine SHALL have three states, IDLE, DRAIN and CLEAR, with these transitions:
- IDLE to DRAIN on clear_req when the FIFO is non-empty
- IDLE to CLEAR on clear_req when the FIFO is empty
- DRAIN to CLEAR when the FIFO becomes empty
- CLEAR to IDLE after the final sweep write
REQ-013 In DRAIN, the FIFO SHALL keep popping as in IDLE while in_ready is held at 0.
REQ-014 CLEAR SHALL sweep bank 0 address 0 up to address DEPTH-1, then bank 1, and so on through bank NUM_BANKS-1 address DEPTH-1.
REQ-015 Each sweep write SHALL issue one wea pulse with dia=CLEAR_VALUE, and only on cycles where write_allow=1; the sweep SHALL stall, holding its position, while write_allow=0.
REQ-016 clear_busy SHALL be 1 from the edge after clear_req is accepted until the edge on which the state returns to IDLE.
REQ-017 clear_req SHALL be ignored while in DRAIN or CLEAR.
REQ-018 in_valid while in_ready=0 SHALL be ignored, with no side effects.

Reset
REQ-019 Asserting reset_n low SHALL immediately set the following, including mid-drain or mid-sweep:
- wea=0, banka=0, addra=0, dia=0
- fifo_level=0, FIFO empty
- state=IDLE, sweep counters=0
- clear_busy=0, in_ready=0
REQ-020 After reset_n deasserts, in_ready SHALL rise to 1 on the first clk edge.

Configuration
REQ-021 With macro MEM_BANK_WRITER_CLEAR_EN defined, DRAIN, CLEAR and clear_busy SHALL behave as specified above.
REQ-022 With MEM_BANK_WRITER_CLEAR_EN undefined:
- clear_req SHALL be ignored
- clear_busy SHALL be tied to 0
- the state SHALL remain IDLE
- no sweep logic SHALL be synthesized

Verification
REQ-023 Single write: write_allow=1; push bank=1 addr=5 data=0xA3 at edge 0 -> after edge 1 wea=1, banka=1, addra=5, dia=0xA3; after edge 2 wea=0.
REQ-024 Full queue: write_allow=0; push 5 writes back to back -> first 4 accepted, fifo_level=4, in_ready=0, 5th held; then write_allow=1 -> 4 pulses in order, in_ready returns to 1 after the first pop.
REQ-025 Backpressure: write_allow toggles 1,0,1,0 with 3 queued writes -> wea pulses only after the allowed edges, order preserved, no entry dropped or duplicated.
REQ-026 Clear: NUM_BANKS=2, DEPTH=32, 2 writes queued, clear_req -> the 2 writes are issued, then 64 writes of 0 from bank0/addr0 to bank1/addr31; clear_busy falls after the last; in_valid during the sweep is not accepted.
REQ-027 Reset mid-sweep: assert reset_n after 10 sweep writes -> wea=0, clear_busy=0, fifo_level=0 immediately; after release no further sweep writes occur.
REQ-028 Macro undefined: pulse clear_req with an empty queue -> no wea activity, clear_busy stays 0, in_ready stays 1.
